pcpi_issuer: RTL and testbench

- Initiator side of the PCPI co-processor interface. Lets a simple host or test sequencer drive PCPI responders such as the SHA accelerator without a PicoRV32 core.
- Accepts one custom instruction plus two operands over a valid/ready command channel, then drives the PCPI request. It waits for the responder, applies PicoRV32-style timeout rules, and returns result and status over a valid/ready response channel.
- One command in flight at a time.

---
 rtl/pcpi_issuer.sv | 230 +++++++++++++++++++++++
 tb/tb_pcpi_issuer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_issuer.sv
// PCPI initiator: issues one command to a PCPI responder and returns its result (stats behind PCPI_ISSUER_STATS_EN).
// Latency: pcpi_valid from the accept edge; rsp_valid one edge after ready is sampled, or on timeout/watchdog abort.
// Backpressure: one command in flight; cmd_ready stays low until the response handshakes, then one idle cycle.
module pcpi_issuer #(
   parameter int TIMEOUT_CYCLES  = 16,
   parameter int MAX_WAIT_CYCLES = 1024,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_insn,
   input  logic [31:0]      cmd_rs1,
   input  logic [31:0]      cmd_rs2,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rd,
   output logic             rsp_wr,
   output logic [1:0]       rsp_status,
   output logic             pcpi_valid,
   output logic [31:0]      pcpi_insn,
   output logic [31:0]      pcpi_rs1,
   output logic [31:0]      pcpi_rs2,
   input  logic             pcpi_wr,
   input  logic [31:0]      pcpi_rd,
   input  logic             pcpi_wait,
   input  logic             pcpi_ready
`ifdef PCPI_ISSUER_STATS_EN
   ,
   output logic [31:0]      stat_issued,
   output logic [15:0]      stat_faults,
   output logic [CNT_W-1:0] stat_last_lat
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_ILLEGAL = 2'b01;
   localparam logic [1:0] RSP_HANG    = 2'b10;

   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT_CYCLES);
   localparam bit               WAIT_EN  = (MAX_WAIT_CYCLES != 0);

   state_t           state_q, state_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rd_q, rsp_rd_d;
   logic             rsp_wr_q, rsp_wr_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic             pcpi_valid_q, pcpi_valid_d;
   logic [31:0]      pcpi_insn_q, pcpi_insn_d;
   logic [31:0]      pcpi_rs1_q, pcpi_rs1_d;
   logic [31:0]      pcpi_rs2_q, pcpi_rs2_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rd_d     = rsp_rd_q;
      rsp_wr_d     = rsp_wr_q;
      rsp_status_d = rsp_status_q;
      pcpi_valid_d = pcpi_valid_q;
      pcpi_insn_d  = pcpi_insn_q;
      pcpi_rs1_d   = pcpi_rs1_q;
      pcpi_rs2_d   = pcpi_rs2_q;
      tmo_cnt_d    = tmo_cnt_q;
      wait_cnt_d   = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               pcpi_insn_d  = cmd_insn;
               pcpi_rs1_d   = cmd_rs1;
               pcpi_rs2_d   = cmd_rs2;
               tmo_cnt_d    = '0;
               wait_cnt_d   = '0;
               pcpi_valid_d = 1'b1;
               cmd_ready_d  = 1'b0;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Limits are checked on the registered counts, so an abort lands one cycle after the limit is reached.
            if (pcpi_ready) begin
               rsp_rd_d     = pcpi_rd;
               rsp_wr_d     = pcpi_wr;
               rsp_status_d = RSP_OK;
               pcpi_valid_d = 1'b0;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else if (WAIT_EN && (wait_cnt_q >= WAIT_LIM)) begin
               rsp_rd_d     = '0;
               rsp_wr_d     = 1'b0;
               rsp_status_d = RSP_HANG;
               pcpi_valid_d = 1'b0;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else if (tmo_cnt_q >= TMO_LIM) begin
               rsp_rd_d     = '0;
               rsp_wr_d     = 1'b0;
               rsp_status_d = RSP_ILLEGAL;
               pcpi_valid_d = 1'b0;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else if (pcpi_wait) begin
               tmo_cnt_d = '0;
               if (wait_cnt_q != '1) begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
               end
            end else begin
               wait_cnt_d = '0;
               tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            cmd_ready_d  = 1'b1;
            rsp_valid_d  = 1'b0;
            pcpi_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rd_q     <= '0;
         rsp_wr_q     <= 1'b0;
         rsp_status_q <= RSP_OK;
         pcpi_valid_q <= 1'b0;
         pcpi_insn_q  <= '0;
         pcpi_rs1_q   <= '0;
         pcpi_rs2_q   <= '0;
         tmo_cnt_q    <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rd_q     <= rsp_rd_d;
         rsp_wr_q     <= rsp_wr_d;
         rsp_status_q <= rsp_status_d;
         pcpi_valid_q <= pcpi_valid_d;
         pcpi_insn_q  <= pcpi_insn_d;
         pcpi_rs1_q   <= pcpi_rs1_d;
         pcpi_rs2_q   <= pcpi_rs2_d;
         tmo_cnt_q    <= tmo_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rd     = rsp_rd_q;
   assign rsp_wr     = rsp_wr_q;
   assign rsp_status = rsp_status_q;
   assign pcpi_valid = pcpi_valid_q;
   assign pcpi_insn  = pcpi_insn_q;
   assign pcpi_rs1   = pcpi_rs1_q;
   assign pcpi_rs2   = pcpi_rs2_q;

`ifdef PCPI_ISSUER_STATS_EN
   logic [31:0]      stat_issued_q, stat_issued_d;
   logic [15:0]      stat_faults_q, stat_faults_d;
   logic [CNT_W-1:0] stat_last_lat_q, stat_last_lat_d;
   logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;

   // lat_cnt counts ISSUE cycles, which equals edges from accept to rsp_valid.
   always_comb begin
      stat_issued_d   = stat_issued_q;
      stat_faults_d   = stat_faults_q;
      stat_last_lat_d = stat_last_lat_q;
      lat_cnt_d       = lat_cnt_q;
      if ((state_q == ST_IDLE) && cmd_valid && cmd_ready_q) begin
         lat_cnt_d = '0;
         if (stat_issued_q != '1) begin
            stat_issued_d = stat_issued_q + 32'd1;
         end
      end
      if (state_q == ST_ISSUE) begin
         if (lat_cnt_q != '1) begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
         end
         if (state_d == ST_RESP) begin
            stat_last_lat_d = lat_cnt_d;
            if ((rsp_status_d != RSP_OK) && (stat_faults_q != '1)) begin
               stat_faults_d = stat_faults_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued_q   <= '0;
         stat_faults_q   <= '0;
         stat_last_lat_q <= '0;
         lat_cnt_q       <= '0;
      end else begin
         stat_issued_q   <= stat_issued_d;
         stat_faults_q   <= stat_faults_d;
         stat_last_lat_q <= stat_last_lat_d;
         lat_cnt_q       <= lat_cnt_d;
      end
   end

   assign stat_issued   = stat_issued_q;
   assign stat_faults   = stat_faults_q;
   assign stat_last_lat = stat_last_lat_q;
`endif

endmodule

// File: tb/tb_pcpi_issuer.sv
// Directed bench for pcpi_issuer with TIMEOUT_CYCLES=16 and MAX_WAIT_CYCLES=8.
module tb_pcpi_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rd;
   logic        rsp_wr;
   logic [1:0]  rsp_status;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;
`ifdef PCPI_ISSUER_STATS_EN
   logic [31:0] stat_issued;
   logic [15:0] stat_faults;
   logic [15:0] stat_last_lat;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pcpi_issuer #(
      .TIMEOUT_CYCLES (16),
      .MAX_WAIT_CYCLES(8),
      .CNT_W          (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_insn  (cmd_insn),
      .cmd_rs1   (cmd_rs1),
      .cmd_rs2   (cmd_rs2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rd    (rsp_rd),
      .rsp_wr    (rsp_wr),
      .rsp_status(rsp_status),
      .pcpi_valid(pcpi_valid),
      .pcpi_insn (pcpi_insn),
      .pcpi_rs1  (pcpi_rs1),
      .pcpi_rs2  (pcpi_rs2),
      .pcpi_wr   (pcpi_wr),
      .pcpi_rd   (pcpi_rd),
      .pcpi_wait (pcpi_wait),
      .pcpi_ready(pcpi_ready)
`ifdef PCPI_ISSUER_STATS_EN
      ,
      .stat_issued  (stat_issued),
      .stat_faults  (stat_faults),
      .stat_last_lat(stat_last_lat)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
      cmd_valid = 1'b1;
      cmd_insn  = insn;
      cmd_rs1   = rs1;
      cmd_rs2   = rs2;
      tick();
      cmd_valid = 1'b0;
   endtask

   // mode 0: wait for wait_n valid cycles then ready; mode 1: silent; mode 2: wait forever.
   task automatic run_responder(input int mode, input int wait_n, input logic [31:0] rd_val,
                                input logic wr_val, output int vld_cycles, output bit got_rsp);
      vld_cycles = 0;
      for (int i = 0; i < 200 && !rsp_valid; i++) begin
         pcpi_rd    = rd_val;
         pcpi_wr    = wr_val;
         pcpi_wait  = 1'b0;
         pcpi_ready = 1'b0;
         if (pcpi_valid) begin
            vld_cycles++;
            case (mode)
               0: begin
                  pcpi_wait  = (vld_cycles <= wait_n);
                  pcpi_ready = (vld_cycles > wait_n);
               end
               2: pcpi_wait = 1'b1;
               default: ;
            endcase
         end
         tick();
      end
      pcpi_wait  = 1'b0;
      pcpi_ready = 1'b0;
      got_rsp    = rsp_valid;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
      end
      checks++;
      if ({rsp_valid, rsp_wr, rsp_status, pcpi_valid} !== 5'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=00000", {rsp_valid, rsp_wr, rsp_status, pcpi_valid});
      end
      checks++;
      if ({rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2} !== 128'd0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2});
      end
   endtask

   task automatic test_ignore_idle();
      int seen = 0;
      pcpi_ready = 1'b1;
      pcpi_wait  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid || pcpi_valid || !cmd_ready) seen++;
      end
      pcpi_ready = 1'b0;
      pcpi_wait  = 1'b0;
      checks++;
      if (seen !== 0) begin
         failures++; $display("FAIL idle_ignore bad_cycles=%0d exp=0", seen);
      end
   endtask

   task automatic test_comb_ready();
      int vld; bit got;
      issue_cmd(32'h0200000B, 32'h00000011, 32'h00000022);
      checks++;
      if ({pcpi_valid, cmd_ready, pcpi_insn, pcpi_rs1, pcpi_rs2} !== {1'b1, 1'b0, 32'h0200000B, 32'h11, 32'h22}) begin
         failures++; $display("FAIL comb_issue got v=%b cr=%b insn=%h rs1=%h rs2=%h", pcpi_valid, cmd_ready, pcpi_insn, pcpi_rs1, pcpi_rs2);
      end
      run_responder(0, 0, 32'hDEADBEEF, 1'b1, vld, got);
      checks++;
      if (!got || vld !== 1) begin
         failures++; $display("FAIL comb_latency got_rsp=%b valid_cycles=%0d exp=1", got, vld);
      end
      checks++;
      if ({pcpi_valid, rsp_rd, rsp_wr, rsp_status} !== {1'b0, 32'hDEADBEEF, 1'b1, 2'b00}) begin
         failures++; $display("FAIL comb_rsp got v=%b rd=%h wr=%b st=%b exp rd=deadbeef wr=1 st=00", pcpi_valid, rsp_rd, rsp_wr, rsp_status);
      end
      finish_rsp();
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         failures++; $display("FAIL comb_handshake got rsp_valid=%b cmd_ready=%b exp 0/1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_wait_then_ready();
      int vld; bit got;
      issue_cmd(32'h0400000B, 32'hA5A5A5A5, 32'h5A5A5A5A);
      run_responder(0, 5, 32'h12345678, 1'b0, vld, got);
      checks++;
      if (!got || vld !== 6) begin
         failures++; $display("FAIL wait_latency got_rsp=%b valid_cycles=%0d exp=6", got, vld);
      end
      checks++;
      if ({rsp_rd, rsp_wr, rsp_status} !== {32'h12345678, 1'b0, 2'b00}) begin
         failures++; $display("FAIL wait_rsp got rd=%h wr=%b st=%b exp 12345678/0/00", rsp_rd, rsp_wr, rsp_status);
      end
      finish_rsp();
   endtask

   task automatic test_timeout();
      int vld; bit got;
      issue_cmd(32'h0600000B, 32'h1, 32'h2);
      run_responder(1, 0, 32'hCAFEF00D, 1'b1, vld, got);
      checks++;
      if (!got || vld !== 17) begin
         failures++; $display("FAIL timeout_latency got_rsp=%b valid_cycles=%0d exp=17", got, vld);
      end
      checks++;
      if ({pcpi_valid, rsp_rd, rsp_wr, rsp_status} !== {1'b0, 32'd0, 1'b0, 2'b01}) begin
         failures++; $display("FAIL timeout_rsp got v=%b rd=%h wr=%b st=%b exp 0/0/0/01", pcpi_valid, rsp_rd, rsp_wr, rsp_status);
      end
      finish_rsp();
   endtask

   task automatic test_hang();
      int vld; bit got;
      issue_cmd(32'h0800000B, 32'h3, 32'h4);
      run_responder(2, 0, 32'hBADC0DE5, 1'b1, vld, got);
      checks++;
      if (!got || vld !== 9) begin
         failures++; $display("FAIL hang_latency got_rsp=%b valid_cycles=%0d exp=9", got, vld);
      end
      checks++;
      if ({pcpi_valid, rsp_rd, rsp_wr, rsp_status} !== {1'b0, 32'd0, 1'b0, 2'b10}) begin
         failures++; $display("FAIL hang_rsp got v=%b rd=%h wr=%b st=%b exp 0/0/0/10", pcpi_valid, rsp_rd, rsp_wr, rsp_status);
      end
      finish_rsp();
   endtask

   task automatic test_back_to_back();
      int vld; bit got; int bad = 0;
      issue_cmd(32'h0A00000B, 32'h5, 32'h6);
      run_responder(0, 1, 32'h0BADF00D, 1'b1, vld, got);
      cmd_valid = 1'b1;
      cmd_insn  = 32'h0C00000B;
      cmd_rs1   = 32'h77;
      cmd_rs2   = 32'h88;
      for (int i = 0; i < 4; i++) begin
         tick();
         if ({rsp_valid, cmd_ready, pcpi_valid, rsp_rd, rsp_wr, rsp_status} !== {3'b100, 32'h0BADF00D, 1'b1, 2'b00}) bad++;
      end
      checks++;
      if (!got || bad !== 0) begin
         failures++; $display("FAIL bp_hold got_rsp=%b unstable_cycles=%0d exp=0", got, bad);
      end
      finish_rsp();
      checks++;
      if ({rsp_valid, cmd_ready, pcpi_valid} !== 3'b010) begin
         failures++; $display("FAIL bp_idle got rv=%b cr=%b pv=%b exp 0/1/0", rsp_valid, cmd_ready, pcpi_valid);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({pcpi_valid, cmd_ready, pcpi_insn, pcpi_rs1} !== {2'b10, 32'h0C00000B, 32'h77}) begin
         failures++; $display("FAIL bp_accept got pv=%b cr=%b insn=%h rs1=%h", pcpi_valid, cmd_ready, pcpi_insn, pcpi_rs1);
      end
      run_responder(0, 0, 32'h00C0FFEE, 1'b0, vld, got);
      finish_rsp();
   endtask

   task automatic test_reset_mid();
      int vld; bit got; int rsp_seen = 0;
      issue_cmd(32'h0E00000B, 32'h9, 32'hA);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({pcpi_valid, rsp_valid, cmd_ready} !== 3'b001) begin
         failures++; $display("FAIL rst_mid got pv=%b rv=%b cr=%b exp 0/0/1", pcpi_valid, rsp_valid, cmd_ready);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rsp_valid || pcpi_valid) rsp_seen++;
      end
      checks++;
      if (rsp_seen !== 0) begin
         failures++; $display("FAIL rst_silent bad_cycles=%0d exp=0", rsp_seen);
      end
      issue_cmd(32'h1000000B, 32'hB, 32'hC);
      run_responder(0, 2, 32'h13572468, 1'b1, vld, got);
      checks++;
      if (!got || vld !== 3 || {rsp_rd, rsp_wr, rsp_status} !== {32'h13572468, 1'b1, 2'b00}) begin
         failures++; $display("FAIL rst_recover got_rsp=%b cycles=%0d rd=%h wr=%b st=%b exp 3/13572468/1/00", got, vld, rsp_rd, rsp_wr, rsp_status);
      end
      finish_rsp();
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_insn   = '0;
      cmd_rs1    = '0;
      cmd_rs2    = '0;
      rsp_ready  = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = '0;
      pcpi_wait  = 1'b0;
      pcpi_ready = 1'b0;
      test_reset();
      test_ignore_idle();
      test_comb_ready();
      test_wait_then_ready();
      test_timeout();
      test_hang();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
